cpu_racket_control: RTL and testbench

// - Computer opponent for single-player mode. Drives pos_of_player_2 (racket top y) into the ball FSM.
// - Watches the ball position that the ball FSM produces.
// - Racket moves toward the ball only while the ball approaches the left racket (x decreasing).
// - Racket drifts back to screen centre otherwise. Updates once per frame on end_of_frame.

---
 rtl/cpu_racket_control.sv | 131 +++++++++++++
 tb/tb_cpu_racket_control.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_racket_control.sv
// Computer-controlled player-2 racket. It follows the ball while the ball moves
// toward the left racket, and otherwise drifts back to mid-screen. It updates once per frame.
module cpu_racket_control #(
  parameter int Y_MIN        = 51,
  parameter int Y_MAX        = 717,
  parameter int RACKET_H     = 80,
  parameter int BALL_SIZE    = 15,
  parameter int STEP         = 4,
  parameter int DEAD_ZONE    = 2,
  parameter int REACT_X      = 512,
  parameter int REACT_FRAMES = 2,
  parameter int X_START      = 504
) (
  input  logic        clk65MHz,
  input  logic        rst,
  input  logic        enable,
  input  logic        end_of_frame,
  input  logic [10:0] x_pos_of_ball,
  input  logic [10:0] y_pos_of_ball,
  output logic [9:0]  pos_of_player_2,
  output logic        tracking
);

  localparam logic signed [12:0] LO13     = 13'(Y_MIN);
  localparam logic signed [12:0] HI13     = 13'(Y_MAX - RACKET_H);
  localparam logic signed [12:0] OFF13    = 13'(BALL_SIZE / 2 - RACKET_H / 2);
  localparam logic signed [12:0] STEP13   = 13'(STEP);
  localparam logic signed [12:0] DZ13     = 13'(DEAD_ZONE);
  localparam logic [9:0]         CENTER_Y = 10'((Y_MIN + Y_MAX - RACKET_H) / 2);
  localparam logic [10:0]        REACT_X11 = 11'(REACT_X);
  localparam logic [10:0]        X_START11 = 11'(X_START);
  localparam logic [7:0]         REACT_LOAD = 8'((REACT_FRAMES > 0) ? REACT_FRAMES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_CENTER, S_WAIT, S_TRACK} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  pos_reg, pos_next;
  logic [10:0] prev_x_reg, prev_x_next;
  logic [7:0]  react_cnt_reg, react_cnt_next;
  logic        tracking_reg, tracking_next;

  logic              approaching;
  logic signed [12:0] target_raw;
  logic [9:0]        target;

  function automatic logic [9:0] clamp_pos(input logic signed [12:0] v);
    if (v < LO13) return LO13[9:0];
    if (v > HI13) return HI13[9:0];
    return v[9:0];
  endfunction

  // Step toward goal by at most STEP without overshooting; small errors are ignored.
  function automatic logic [9:0] move_toward(input logic [9:0] pos, input logic [9:0] goal);
    logic signed [12:0] d;
    logic signed [12:0] mag;
    logic signed [12:0] step;
    d    = $signed({3'b000, goal}) - $signed({3'b000, pos});
    mag  = d[12] ? -d : d;
    step = (mag < STEP13) ? mag : STEP13;
    if (mag <= DZ13) return pos;
    if (d[12]) return clamp_pos($signed({3'b000, pos}) - step);
    return clamp_pos($signed({3'b000, pos}) + step);
  endfunction

  assign approaching = (x_pos_of_ball < prev_x_reg);
  assign target_raw  = $signed({2'b00, y_pos_of_ball}) + OFF13;
  assign target      = clamp_pos(target_raw);

  always_comb begin
    state_next     = state_reg;
    pos_next       = pos_reg;
    prev_x_next    = prev_x_reg;
    react_cnt_next = react_cnt_reg;
    if (end_of_frame) prev_x_next = x_pos_of_ball;

    if (!enable) begin
      state_next     = S_IDLE;
      pos_next       = CENTER_Y;
      react_cnt_next = 8'd0;
    end else if (end_of_frame) begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_CENTER;
          pos_next   = CENTER_Y;
        end
        S_CENTER: begin
          pos_next = move_toward(pos_reg, CENTER_Y);
          if (approaching && (x_pos_of_ball < REACT_X11)) begin
            if (REACT_FRAMES == 0) begin
              state_next = S_TRACK;
            end else begin
              state_next     = S_WAIT;
              react_cnt_next = REACT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!approaching)                state_next = S_CENTER;
          else if (react_cnt_reg == 8'd0) state_next = S_TRACK;
          else                             react_cnt_next = react_cnt_reg - 8'd1;
        end
        S_TRACK: begin
          if (!approaching) state_next = S_CENTER;
          else              pos_next   = move_toward(pos_reg, target);
        end
        default: state_next = S_IDLE;
      endcase
    end
    tracking_next = (state_next == S_TRACK);
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      pos_reg       <= CENTER_Y;
      prev_x_reg    <= X_START11;
      react_cnt_reg <= 8'd0;
      tracking_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      prev_x_reg    <= prev_x_next;
      react_cnt_reg <= react_cnt_next;
      tracking_reg  <= tracking_next;
    end
  end

  assign pos_of_player_2 = pos_reg;
  assign tracking        = tracking_reg;

endmodule

// File: tb/tb_cpu_racket_control.sv
// Directed bench for cpu_racket_control: reaction delay, tracking, clamps,
// dead zone, reversal, frame-pulse gating and disable.
module tb_cpu_racket_control;

  logic        clk65MHz = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        end_of_frame = 1'b0;
  logic [10:0] x_pos_of_ball = 11'd504;
  logic [10:0] y_pos_of_ball = 11'd400;
  logic [9:0]  pos_of_player_2;
  logic        tracking;

  int checks = 0;
  int errors = 0;
  int nframes = 0;
  int exp_pos;
  int xv;

  cpu_racket_control dut (
    .clk65MHz(clk65MHz),
    .rst(rst),
    .enable(enable),
    .end_of_frame(end_of_frame),
    .x_pos_of_ball(x_pos_of_ball),
    .y_pos_of_ball(y_pos_of_ball),
    .pos_of_player_2(pos_of_player_2),
    .tracking(tracking)
  );

  always #5 clk65MHz = ~clk65MHz;

  // Reference: target = y - 33 clamped to [51, 637]
  function automatic int ref_target(input int y);
    int t;
    t = y - 33;
    if (t < 51) t = 51;
    if (t > 637) t = 637;
    return t;
  endfunction

  // Reference: hold within +-2, else move by up to 4 without passing the goal
  function automatic int ref_move(input int p, input int g);
    if (g - p >= -2 && g - p <= 2) return p;
    if (g - p > 4) return p + 4;
    if (g - p < -4) return p - 4;
    return g;
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One frame: present ball position with a 1-cycle pulse, sample one cycle later.
  task automatic frame(input int x, input int y);
    @(negedge clk65MHz);
    x_pos_of_ball = 11'(x);
    y_pos_of_ball = 11'(y);
    end_of_frame  = 1'b1;
    @(negedge clk65MHz);
    end_of_frame  = 1'b0;
    nframes++;
    $display("frame %0d x=%0d y=%0d pos=%0d tracking=%0b", nframes, x, y,
             pos_of_player_2, tracking);
  endtask

  // Frames with ball still approaching (x decreasing); racket follows target of y.
  task automatic run_track(input string tag, input int y, input int n);
    for (int i = 0; i < n; i++) begin
      xv = xv - 1;
      frame(xv, y);
      exp_pos = ref_move(exp_pos, ref_target(y));
      check({tag, "_pos"}, int'(pos_of_player_2), exp_pos);
      check({tag, "_trk"}, int'(tracking), 1);
    end
  endtask

  initial begin
    // Reset with frames running while disabled
    repeat (2) @(negedge clk65MHz);
    check("rst_pos", int'(pos_of_player_2), 344);
    check("rst_trk", int'(tracking), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frame(504, 400);
      check("idle_pos", int'(pos_of_player_2), 344);
      check("idle_trk", int'(tracking), 0);
    end

    // Approach with reaction delay
    enable = 1'b1;
    frame(530, 600);
    check("center_trk0", int'(tracking), 0);
    frame(525, 600); check("c525_trk", int'(tracking), 0);
    frame(520, 600); check("c520_trk", int'(tracking), 0);
    frame(515, 600); check("c515_trk", int'(tracking), 0);
    frame(510, 600); check("wait510_trk", int'(tracking), 0);
    check("wait510_pos", int'(pos_of_player_2), 344);
    frame(505, 600); check("wait505_trk", int'(tracking), 0);
    frame(500, 600); check("track500_trk", int'(tracking), 1);
    check("track500_pos", int'(pos_of_player_2), 344);

    xv = 500;
    exp_pos = 344;
    run_track("rise", 600, 60);
    check("reach567", int'(pos_of_player_2), 567);

    run_track("to500", 533, 20);
    check("reach500", int'(pos_of_player_2), 500);

    // Reversal: ball moves away, racket drifts home
    xv = 600;
    frame(xv, 533);
    check("rev_trk", int'(tracking), 0);
    check("rev_pos", int'(pos_of_player_2), 500);
    exp_pos = 500;
    for (int i = 0; i < 42; i++) begin
      xv = xv + 1;
      frame(xv, 533);
      exp_pos = ref_move(exp_pos, 344);
      check("drift_pos", int'(pos_of_player_2), exp_pos);
      check("drift_trk", int'(tracking), 0);
    end
    check("drift_home", int'(pos_of_player_2), 344);

    // Re-engage
    frame(455, 433); check("re_wait1", int'(tracking), 0);
    frame(454, 433); check("re_wait2", int'(tracking), 0);
    frame(453, 433); check("re_track", int'(tracking), 1);
    xv = 453;
    exp_pos = 344;
    run_track("to400", 433, 16);
    check("reach400", int'(pos_of_player_2), 400);

    // Dead zone then partial step
    run_track("dz402", 435, 3);
    check("dz_hold400", int'(pos_of_player_2), 400);
    run_track("step403", 436, 1);
    check("partial403", int'(pos_of_player_2), 403);

    // Clamp low
    run_track("low", 10, 92);
    check("clamp51", int'(pos_of_player_2), 51);

    // Clamp high
    run_track("to54", 87, 2);
    check("reach54", int'(pos_of_player_2), 54);
    run_track("high", 760, 150);
    check("clamp637", int'(pos_of_player_2), 637);

    // No frame pulse: everything holds
    for (int i = 0; i < 4; i++) begin
      repeat (25) @(negedge clk65MHz);
      check("nopulse_pos", int'(pos_of_player_2), 637);
      check("nopulse_trk", int'(tracking), 1);
    end

    // Disable acts without a pulse
    @(negedge clk65MHz);
    enable = 1'b0;
    @(negedge clk65MHz);
    check("dis_pos", int'(pos_of_player_2), 344);
    check("dis_trk", int'(tracking), 0);
    $display("disable: pos=%0d tracking=%0b", pos_of_player_2, tracking);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
